// File: rtl/gate_ex_pkg.sv
// Shared types and widths for the gate exerciser: FSM state encoding and
// index / error-count / settle-counter widths.
package gate_ex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int IDX_W    = 2;
    localparam int ERR_W    = 8;
    localparam int SETTLE_W = 4;
    localparam int PASS_W   = 8;

endpackage

// File: rtl/gate_ex_seq.sv
// Sequencing counters for the gate exerciser: settle counter, combination
// index and pass counter, with the settle-done and last-combination strobes.
module gate_ex_seq
    import gate_ex_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int PASSES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_apply,
    input  logic             in_check,
    output logic [IDX_W-1:0] idx,
    output logic             settle_done,
    output logic             last_comb
);

    localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(SETTLE - 1);
    localparam logic [PASS_W-1:0]   LAST_PASS  = PASS_W'(PASSES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST   = '1;

    logic [SETTLE_W-1:0] settle_cnt;
    logic [PASS_W-1:0]   pass_cnt;

    assign settle_done = in_apply && (settle_cnt == SETTLE_END);
    assign last_comb   = (idx == IDX_LAST) && (pass_cnt == LAST_PASS);

    // Index wraps 3 -> 0 naturally; the pass counter advances on that wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            settle_cnt <= '0;
            idx        <= '0;
            pass_cnt   <= '0;
        end else begin
            if (settle_done) begin
                settle_cnt <= '0;
            end else if (in_apply) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (in_check) begin
                idx <= idx + 1'b1;
                if (idx == IDX_LAST) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gate_exerciser.sv
// Stimulus generator / response checker for a 2-input gate under test.
// Optional macro GATE_EX_FIRST_FAIL_EN adds FIRST_FAIL_VLD / FIRST_FAIL outputs.
module gate_exerciser
    import gate_ex_pkg::*;
#(
    parameter logic [3:0] TRUTH  = 4'b1000,
    parameter int         SETTLE = 2,
    parameter int         PASSES = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             Y_IN,
    output logic             A_OUT,
    output logic             B_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [3:0]       FAIL_VEC
`ifdef GATE_EX_FIRST_FAIL_EN
    ,
    output logic             FIRST_FAIL_VLD,
    output logic [IDX_W-1:0] FIRST_FAIL
`endif
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + 1'b1;
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] apply_idx;
    logic             settle_done;
    logic             last_comb;
    logic             in_apply;
    logic             in_check;
    logic             start_acc;
    logic             enter_apply;
    logic             enter_fin;
    logic             mismatch;

    assign in_apply    = (state == APPLY);
    assign in_check    = (state == CHECK);
    assign start_acc   = (state == IDLE) && START;
    assign enter_fin   = in_check && last_comb;
    assign enter_apply = start_acc || (in_check && !last_comb);
    assign mismatch    = in_check && (Y_IN != TRUTH[idx]);
    // The sequencer advances idx on the same edge, so pre-compute its next value.
    assign apply_idx   = start_acc ? '0 : idx + 1'b1;

    gate_ex_seq #(
        .SETTLE (SETTLE),
        .PASSES (PASSES)
    ) u_seq (
        .clk         (CLK),
        .rst         (RST),
        .clear       (start_acc),
        .in_apply    (in_apply),
        .in_check    (in_check),
        .idx         (idx),
        .settle_done (settle_done),
        .last_comb   (last_comb)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = APPLY;
            APPLY:   if (settle_done) state_nxt = CHECK;
            CHECK:   state_nxt = last_comb ? FIN : APPLY;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drive and status outputs are registered so the gate sees clean edges.
    always_ff @(posedge CLK) begin
        if (RST) begin
            A_OUT <= 1'b0;
            B_OUT <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            BUSY <= (state_nxt == APPLY) || (state_nxt == CHECK);
            DONE <= (state_nxt == FIN);
            if (enter_apply) begin
                {A_OUT, B_OUT} <= apply_idx;
            end else if (enter_fin) begin
                {A_OUT, B_OUT} <= 2'b00;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR_CNT  <= '0;
            FAIL_VEC <= '0;
            PASS     <= 1'b0;
        end else if (start_acc) begin
            ERR_CNT  <= '0;
            FAIL_VEC <= '0;
            PASS     <= 1'b0;
        end else begin
            if (mismatch) begin
                ERR_CNT       <= sat_inc(ERR_CNT);
                FAIL_VEC[idx] <= 1'b1;
            end
            // Fold in the final CHECK result, which lands on this same edge.
            if (enter_fin) begin
                PASS <= (ERR_CNT == '0) && !mismatch;
            end
        end
    end

`ifdef GATE_EX_FIRST_FAIL_EN
    always_ff @(posedge CLK) begin
        if (RST || start_acc) begin
            FIRST_FAIL_VLD <= 1'b0;
            FIRST_FAIL     <= '0;
        end else if (mismatch && !FIRST_FAIL_VLD) begin
            FIRST_FAIL_VLD <= 1'b1;
            FIRST_FAIL     <= idx;
        end
    end
`endif

endmodule

// File: tb/tb_gate_exerciser.sv
// Self-checking bench for gate_exerciser: two instances (SETTLE=2/PASSES=1 and
// SETTLE=1/PASSES=100) against a run-phase arithmetic model plus literal checks.
`timescale 1ns/1ps
module tb_gate_exerciser;

    localparam logic [3:0] TRUTH = 4'b1000;
    localparam int         NI    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      [NI];
    logic       start    [NI];
    logic       y        [NI];
    logic       a        [NI];
    logic       b        [NI];
    logic       busy     [NI];
    logic       done     [NI];
    logic       pass     [NI];
    logic [7:0] err_cnt  [NI];
    logic [3:0] fail_vec [NI];
`ifdef GATE_EX_FIRST_FAIL_EN
    logic       ff_vld   [NI];
    logic [1:0] ff       [NI];
`endif

    // Gate under test selection: 0 AND, 1 OR, 2 tied 1, 3 random, 4 correct only in CHECK
    int   gate_sel [NI] = '{0, 0};
    logic y_rnd    [NI] = '{1'b0, 1'b0};
    logic y_sp     [NI] = '{1'b0, 1'b0};

    int n_checks = 0;
    int n_errors = 0;

    // Model state: mode 0 idle, 1 running (phase 1..N), 2 done cycle
    int         m_mode  [NI] = '{0, 0};
    int         m_phase [NI] = '{0, 0};
    int         m_errs  [NI] = '{0, 0};
    logic [3:0] m_fvec  [NI] = '{4'h0, 4'h0};
    logic       m_pass  [NI] = '{1'b0, 1'b0};
    logic       m_ffv   [NI] = '{1'b0, 1'b0};
    logic [1:0] m_ff    [NI] = '{2'b00, 2'b00};
    logic       m_check [NI] = '{1'b0, 1'b0};
    logic       s_rst   [NI] = '{1'b1, 1'b1};
    logic       s_start [NI] = '{1'b0, 1'b0};
    logic       s_y     [NI] = '{1'b0, 1'b0};

    function automatic int settle_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int passes_of(input int k);
        return (k == 0) ? 1 : 100;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gate_exerciser #(
            .TRUTH  (TRUTH),
            .SETTLE ((g == 0) ? 2 : 1),
            .PASSES ((g == 0) ? 1 : 100)
        ) u_dut (
            .CLK      (clk),
            .RST      (rst[g]),
            .START    (start[g]),
            .Y_IN     (y[g]),
            .A_OUT    (a[g]),
            .B_OUT    (b[g]),
            .BUSY     (busy[g]),
            .DONE     (done[g]),
            .PASS     (pass[g]),
            .ERR_CNT  (err_cnt[g]),
            .FAIL_VEC (fail_vec[g])
`ifdef GATE_EX_FIRST_FAIL_EN
            ,
            .FIRST_FAIL_VLD (ff_vld[g]),
            .FIRST_FAIL     (ff[g])
`endif
        );
    end

    always_comb begin
        for (int k = 0; k < NI; k++) begin
            y[k] = 1'b0;
            case (gate_sel[k])
                0:       y[k] = a[k] & b[k];
                1:       y[k] = a[k] | b[k];
                2:       y[k] = 1'b1;
                3:       y[k] = y_rnd[k];
                default: y[k] = y_sp[k];
            endcase
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic logic [31:0] act_vec(input int k);
        logic [31:0] v;
        v = {15'b0, busy[k], done[k], a[k], b[k], pass[k], err_cnt[k], fail_vec[k]};
`ifdef GATE_EX_FIRST_FAIL_EN
        v[31:29] = {ff_vld[k], ff[k]};
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_vec(input int k);
        logic [31:0] v;
        logic [7:0]  e;
        int          s1;
        int          ix;
        s1 = settle_of(k) + 1;
        ix = (m_mode[k] == 1) ? ((m_phase[k] - 1) / s1) % 4 : 0;
        e  = (m_errs[k] > 255) ? 8'd255 : m_errs[k][7:0];
        v  = {15'b0, m_mode[k] == 1, m_mode[k] == 2, ix[1], ix[0], m_pass[k], e, m_fvec[k]};
`ifdef GATE_EX_FIRST_FAIL_EN
        v[31:29] = {m_ffv[k], m_ff[k]};
`endif
        return v;
    endfunction

    // Reference model: advance by one cycle using the inputs seen at this edge.
    always @(posedge clk) begin : p_model
        int s1;
        int n;
        int ix;
        for (int k = 0; k < NI; k++) begin
            s1 = settle_of(k) + 1;
            n  = passes_of(k) * 4 * s1;
            if (s_rst[k]) begin
                m_mode[k] = 0; m_errs[k] = 0; m_fvec[k] = 4'h0;
                m_pass[k] = 1'b0; m_ffv[k] = 1'b0; m_ff[k] = 2'b00;
            end else begin
                case (m_mode[k])
                    0: if (s_start[k]) begin
                        m_mode[k] = 1; m_phase[k] = 1; m_errs[k] = 0; m_fvec[k] = 4'h0;
                        m_pass[k] = 1'b0; m_ffv[k] = 1'b0; m_ff[k] = 2'b00;
                    end
                    1: begin
                        if ((m_phase[k] - 1) % s1 == s1 - 1) begin
                            ix = ((m_phase[k] - 1) / s1) % 4;
                            if (s_y[k] != TRUTH[ix]) begin
                                m_errs[k]++;
                                m_fvec[k][ix] = 1'b1;
                                if (!m_ffv[k]) begin
                                    m_ffv[k] = 1'b1;
                                    m_ff[k]  = ix[1:0];
                                end
                            end
                        end
                        if (m_phase[k] == n) begin
                            m_mode[k] = 2;
                            m_pass[k] = (m_errs[k] == 0);
                        end else begin
                            m_phase[k]++;
                        end
                    end
                    default: m_mode[k] = 0;
                endcase
            end
            m_check[k] = (m_mode[k] == 1) && ((m_phase[k] - 1) % s1 == s1 - 1);
        end
    end

    // Compare every cycle, then latch the inputs the DUT will sample next edge.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("outputs[%0d]", k), act_vec(k), exp_vec(k));
        end
        for (int k = 0; k < NI; k++) begin
            s_rst[k]   = rst[k];
            s_start[k] = start[k];
            s_y[k]     = y[k];
        end
    end

    initial begin : p_ydrv
        int ix;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < NI; k++) begin
                y_rnd[k] = 1'($urandom);
                ix       = ((m_phase[k] - 1) / (settle_of(k) + 1)) % 4;
                y_sp[k]  = m_check[k] ? TRUTH[ix] : ~TRUTH[ix];
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run_once(input int k, input int budget, output int busy_n,
                            output int done_at, output logic [23:0] ab_seq);
        busy_n  = 0;
        done_at = 0;
        ab_seq  = '0;
        start[k] = 1'b1;
        cyc(1);
        start[k] = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (done[k]) begin
                done_at = c;
                break;
            end
            if (busy[k]) begin
                busy_n++;
                ab_seq = {ab_seq[21:0], a[k], b[k]};
            end
            cyc(1);
        end
        if (done_at == 0) chk($sformatf("done_timeout[%0d]", k), {31'b0, done[k]}, 32'd1);
    endtask

    initial begin : p_main
        int          busy_n;
        int          done_at;
        logic [23:0] ab_seq;
        int          dut_d;
        int          mod_d;

        for (int k = 0; k < NI; k++) begin
            rst[k]   = 1'b1;
            start[k] = 1'b0;
        end
        cyc(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        cyc(2);
        chk("reset_busy", {31'b0, busy[0]}, 32'd0);
        chk("reset_err",  {24'b0, err_cnt[0]}, 32'd0);

        // AND gate, defaults: 12 busy cycles, DONE on cycle 13, clean result
        gate_sel[0] = 0;
        run_once(0, 40, busy_n, done_at, ab_seq);
        chk("and_busy_cycles", busy_n, 32'd12);
        chk("and_done_cycle",  done_at, 32'd13);
        chk("and_ab_sequence", {8'b0, ab_seq}, 32'h0015ABF);
        chk("and_pass", {31'b0, pass[0]}, 32'd1);
        chk("and_err",  {24'b0, err_cnt[0]}, 32'd0);
        chk("and_fvec", {28'b0, fail_vec[0]}, 32'd0);
        cyc(3);

        // OR gate against AND truth table: combinations 01 and 10 mismatch
        gate_sel[0] = 1;
        run_once(0, 40, busy_n, done_at, ab_seq);
        chk("or_pass", {31'b0, pass[0]}, 32'd0);
        chk("or_err",  {24'b0, err_cnt[0]}, 32'd2);
        chk("or_fvec", {28'b0, fail_vec[0]}, 32'h6);
        chk("or_model_err", m_errs[0], 32'd2);
`ifdef GATE_EX_FIRST_FAIL_EN
        chk("or_first_fail", {29'b0, ff_vld[0], ff[0]}, 32'h5);
`endif
        cyc(3);

        // Reset in cycle 5 of a run: outputs return to reset values, no DONE
        gate_sel[0] = 0;
        start[0] = 1'b1;
        cyc(1);
        start[0] = 1'b0;
        cyc(4);
        rst[0] = 1'b1;
        cyc(1);
        rst[0] = 1'b0;
        chk("midrst_busy", {31'b0, busy[0]}, 32'd0);
        chk("midrst_ab",   {30'b0, a[0], b[0]}, 32'd0);
        chk("midrst_pass", {31'b0, pass[0]}, 32'd0);
        dut_d = 0;
        for (int i = 0; i < 20; i++) begin
            if (done[0]) dut_d++;
            cyc(1);
        end
        chk("midrst_no_done", dut_d, 32'd0);
        run_once(0, 40, busy_n, done_at, ab_seq);
        chk("after_rst_pass", {31'b0, pass[0]}, 32'd1);
        chk("after_rst_done_cycle", done_at, 32'd13);
        cyc(2);

        // START held high: back-to-back runs, model checks BUSY never drops mid-run
        start[0] = 1'b1;
        dut_d = 0;
        mod_d = 0;
        for (int i = 0; i < 70; i++) begin
            cyc(1);
            if (done[0]) dut_d++;
            if (m_mode[0] == 2) mod_d++;
        end
        start[0] = 1'b0;
        chk("held_done_count", dut_d, mod_d);
        cyc(20);

        // Y tied 1 for 100 passes: 300 mismatches saturate the count
        gate_sel[1] = 2;
        run_once(1, 1000, busy_n, done_at, ab_seq);
        chk("sat_busy_cycles", busy_n, 32'd800);
        chk("sat_err",  {24'b0, err_cnt[1]}, 32'd255);
        chk("sat_fvec", {28'b0, fail_vec[1]}, 32'h7);
        chk("sat_pass", {31'b0, pass[1]}, 32'd0);
        chk("sat_model_errs", m_errs[1], 32'd300);
        cyc(3);

        // Y correct only during CHECK: single-point sampling gives a clean run
        gate_sel[1] = 4;
        run_once(1, 1000, busy_n, done_at, ab_seq);
        chk("sp_pass", {31'b0, pass[1]}, 32'd1);
        chk("sp_err",  {24'b0, err_cnt[1]}, 32'd0);
        cyc(3);

        // Random Y, random START pulses and occasional resets
        gate_sel[0] = 3;
        for (int i = 0; i < 600; i++) begin
            start[0] = ($urandom_range(0, 5) == 0);
            rst[0]   = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        start[0] = 1'b0;
        rst[0]   = 1'b0;
        cyc(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
